// File: rtl/dsp_result_drain_pkg.sv
// Shared constants and result type for the DSP48A1 output-side drain logic.
package dsp_result_drain_pkg;

    localparam int unsigned P_WIDTH    = 48;
    localparam int unsigned LAT_MAX    = 4;
    localparam int unsigned LAT_W      = 3;
    localparam int unsigned IDX_W      = $clog2(LAT_MAX);
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic               carry;
        logic [P_WIDTH-1:0] p;
    } result_t;

endpackage

// File: rtl/dsp_result_drain_fifo.sv
// First-word-fall-through synchronous FIFO holding slice results, with occupancy count.
module dsp_result_drain_fifo
    import dsp_result_drain_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  result_t                data_i,
    input  logic                   pop_i,
    output logic                   valid_o,
    output result_t                data_o,
    output logic [$clog2(Depth):0] count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    result_t         mem_q [Depth];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic            pop;

    assign valid_o = (count_q != '0);
    // A pop request against an empty FIFO is ignored; there is no push->pop bypass.
    assign pop     = pop_i & valid_o;
    assign data_o  = mem_q[rptr_q];
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        case ({push_i, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_i) begin
                mem_q[wptr_q] <= data_i;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Upstream credit logic must never let a result arrive with no free slot.
    assert property (@(posedge clk) disable iff (!rst_n) !(push_i && count_q == CntW'(Depth)));

endmodule

// File: rtl/dsp_result_drain.sv
// Tracks operand sets through the slice pipeline, captures emerging results into a FIFO and
// drives the slice-wide clock enable so every in-flight result is guaranteed a FIFO slot.
module dsp_result_drain
    import dsp_result_drain_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [LAT_W-1:0]   lat_i,
    input  logic               issue_valid_i,
    output logic               issue_ready_o,
    output logic               slice_ce_o,
    input  logic [P_WIDTH-1:0] p_i,
    input  logic               carry_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [P_WIDTH-1:0] out_p_o,
    output logic               out_carry_o,
    output logic [CNT_W-1:0]   fifo_count_o,
    output logic               proto_err_o
);

    logic [LAT_MAX-1:0] vpipe_q, vpipe_d;
    logic [LAT_W-1:0]   lat_q, lat_d, lat_clamp, inflight;
    logic               proto_err_q, proto_err_d;
    logic [IDX_W-1:0]   tap;
    logic [CNT_W:0]     occupancy;
    logic               res_here, slice_ce, push;
    logic [CNT_W-1:0]   fifo_count;
    result_t            push_data, head;

    always_comb begin
        lat_clamp = (lat_i > LAT_W'(LAT_MAX)) ? LAT_W'(LAT_MAX) : lat_i;
        inflight  = '0;
        for (int unsigned i = 0; i < LAT_MAX; i++) begin
            inflight = inflight + LAT_W'(vpipe_q[i]);
        end
        tap       = IDX_W'(lat_q - 1'b1);
        res_here  = (lat_q == '0) ? issue_valid_i : vpipe_q[tap];
        occupancy = (CNT_W + 1)'(fifo_count) + (CNT_W + 1)'(inflight);
        slice_ce  = occupancy < (CNT_W + 1)'(FIFO_DEPTH);
        push      = slice_ce & res_here;
    end

    // Tags past the configured depth are cleared so a later latency increase never
    // resurrects results that have already been pushed.
    always_comb begin
        vpipe_d = vpipe_q;
        if (slice_ce) begin
            vpipe_d[0] = issue_valid_i & (lat_q != '0);
            for (int unsigned i = 1; i < LAT_MAX; i++) begin
                vpipe_d[i] = vpipe_q[i-1] & (LAT_W'(i) < lat_q);
            end
        end
    end

    always_comb begin
        lat_d       = lat_q;
        proto_err_d = proto_err_q;
        if (inflight == '0) begin
            lat_d = lat_clamp;
        end else if (lat_clamp != lat_q) begin
            proto_err_d = 1'b1;
        end
        if (issue_valid_i && !slice_ce) begin
            proto_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe_q     <= '0;
            lat_q       <= '0;
            proto_err_q <= 1'b0;
        end else begin
            vpipe_q     <= vpipe_d;
            lat_q       <= lat_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign push_data = '{carry: carry_i, p: p_i};

    dsp_result_drain_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (out_ready_i),
        .valid_o (out_valid_o),
        .data_o  (head),
        .count_o (fifo_count)
    );

    assign issue_ready_o = slice_ce;
    assign slice_ce_o    = slice_ce;
    assign out_p_o       = head.p;
    assign out_carry_o   = head.carry;
    assign fifo_count_o  = fifo_count;
    assign proto_err_o   = proto_err_q;

endmodule

// File: tb/tb_dsp_result_drain.sv
// Directed bench: behavioural slice model feeds the drain; a scoreboard checks result order/data.
module tb_dsp_result_drain;
    import dsp_result_drain_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [LAT_W-1:0]   lat;
    logic               issue_valid, issue_ready, slice_ce;
    logic [P_WIDTH-1:0] p_in, out_p;
    logic               carry_in, out_valid, out_ready, out_carry, proto_err;
    logic [CNT_W-1:0]   fifo_count;

    int      checks = 0;
    int      errors = 0;
    result_t sb[$];
    logic [31:0] op;
    int      slice_lat;
    result_t spipe [LAT_MAX];
    result_t slice_out;

    always #5 clk = ~clk;

    dsp_result_drain dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .lat_i         (lat),
        .issue_valid_i (issue_valid),
        .issue_ready_o (issue_ready),
        .slice_ce_o    (slice_ce),
        .p_i           (p_in),
        .carry_i       (carry_in),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_p_o       (out_p),
        .out_carry_o   (out_carry),
        .fifo_count_o  (fifo_count),
        .proto_err_o   (proto_err)
    );

    function automatic result_t res_f(input logic [31:0] x);
        result_t r;
        r.p     = {x, 16'hA5C3} ^ 48'h0123_4567_89AB;
        r.carry = ^x;
        return r;
    endfunction

    // Slice model: operand-to-P pipeline of depth slice_lat, frozen when slice_ce is low.
    always @(posedge clk) begin
        if (slice_ce) begin
            spipe[0] <= res_f(op);
            for (int i = 1; i < LAT_MAX; i++) spipe[i] <= spipe[i-1];
        end
    end
    assign slice_out = (slice_lat == 0) ? res_f(op) : spipe[slice_lat-1];
    assign p_in      = slice_out.p;
    assign carry_in  = slice_out.carry;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: sample 1ns before each rising edge.
    always @(negedge clk) begin
        #4;
        if (rst_n) begin
            if (issue_valid && slice_ce) sb.push_back(res_f(op));
            if (out_valid && out_ready) begin
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL extra_result observed=out_valid expected=no_result");
                end
                if (sb.size() != 0) begin
                    result_t e;
                    e = sb.pop_front();
                    chk("out_p", 64'(out_p), 64'(e.p));
                    chk("out_carry", 64'(out_carry), 64'(e.carry));
                end
            end
        end
    end

    task automatic drain(input string tag);
        int n = 0;
        issue_valid = 1'b0;
        out_ready   = 1'b1;
        while ((sb.size() != 0 || out_valid) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n       = 1'b0;
        sb.delete();
        issue_valid = 1'b0;
        #1;
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_count"}, 64'(fifo_count), 64'd0);
        chk({tag, "_ce"}, 64'(slice_ce), 64'd1);
        chk({tag, "_err"}, 64'(proto_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        rst_n = 1'b0; lat = '0; issue_valid = 1'b0; op = '0; out_ready = 1'b0; slice_lat = 0;
        #3;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_ce", 64'(slice_ce), 64'd1);
        chk("rst_ready", 64'(issue_ready), 64'd1);
        chk("rst_err", 64'(proto_err), 64'd0);
        chk("rst_p", 64'(out_p), 64'd0);
        chk("rst_carry", 64'(out_carry), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // lat 0: each result visible the cycle after issue
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            op = 32'h100 + k; issue_valid = 1'b1;
            @(negedge clk);
            chk("t1_valid", 64'(out_valid), 64'd1);
            chk("t1_count", 64'(fifo_count), 64'd1);
        end
        drain("t1");

        // lat 3, downstream stalled: pipe plus FIFO fills to 4 then freezes
        out_ready = 1'b0; lat = 3'd3; slice_lat = 3;
        @(negedge clk);
        acc = 0;
        for (int n = 0; n < 10; n++) begin
            if (slice_ce) begin
                op = 32'h200 + acc; issue_valid = 1'b1; acc++;
            end else begin
                issue_valid = 1'b0;
            end
            @(negedge clk);
        end
        issue_valid = 1'b0;
        chk("t2_accepted", 64'(acc), 64'd4);
        chk("t2_sb_size", 64'(sb.size()), 64'd4);
        chk("t2_ce_low", 64'(slice_ce), 64'd0);
        chk("t2_count", 64'(fifo_count), 64'd1);
        chk("t2_no_err", 64'(proto_err), 64'd0);
        drain("t2");
        chk("t2_ce_back", 64'(slice_ce), 64'd1);

        // lat 0: fill FIFO, dropped issue, then push+pop at the highest pushable count
        out_ready = 1'b0; lat = '0; slice_lat = 0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            op = 32'h300 + k; issue_valid = 1'b1;
            @(negedge clk);
        end
        issue_valid = 1'b0;
        chk("t3_full", 64'(fifo_count), 64'd4);
        chk("t3_ce_full", 64'(slice_ce), 64'd0);
        chk("t3_ready_full", 64'(issue_ready), 64'd0);
        op = 32'h3FF; issue_valid = 1'b1;
        @(negedge clk);
        issue_valid = 1'b0;
        chk("t3_drop_err", 64'(proto_err), 64'd1);
        chk("t3_drop_count", 64'(fifo_count), 64'd4);
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_pop_count", 64'(fifo_count), 64'd3);
        op = 32'h310; issue_valid = 1'b1;
        @(negedge clk);
        issue_valid = 1'b0;
        chk("t3_pushpop_count", 64'(fifo_count), 64'd3);
        drain("t3");

        // latency change while busy is ignored and flagged
        do_reset("t4_rst");
        lat = 3'd2; slice_lat = 2; out_ready = 1'b1;
        @(negedge clk);
        op = 32'h400; issue_valid = 1'b1;
        @(negedge clk);
        op = 32'h401;
        @(negedge clk);
        issue_valid = 1'b0; lat = 3'd1;
        @(negedge clk);
        lat = 3'd2;
        chk("t4_busy_err", 64'(proto_err), 64'd1);
        drain("t4");

        // latency change while idle is accepted silently
        do_reset("t4b_rst");
        lat = 3'd2;
        @(negedge clk);
        lat = 3'd1; slice_lat = 1;
        @(negedge clk);
        chk("t4b_no_err", 64'(proto_err), 64'd0);
        op = 32'h410; issue_valid = 1'b1;
        @(negedge clk);
        issue_valid = 1'b0;
        chk("t4b_wait", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("t4b_out", 64'(out_valid), 64'd1);
        drain("t4b");

        // async reset in the middle of a burst
        lat = 3'd3; slice_lat = 3; out_ready = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            op = 32'h500 + k; issue_valid = 1'b1;
            @(negedge clk);
        end
        issue_valid = 1'b0;
        @(negedge clk);
        chk("t5_pre_valid", 64'(out_valid), 64'd1);
        op = 32'h5FF; issue_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        sb.delete();
        issue_valid = 1'b0;
        #1;
        chk("t5_valid", 64'(out_valid), 64'd0);
        chk("t5_count", 64'(fifo_count), 64'd0);
        chk("t5_ce", 64'(slice_ce), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // post-reset sanity at lat 0
        lat = '0; slice_lat = 0; out_ready = 1'b1;
        op = 32'h600; issue_valid = 1'b1;
        @(negedge clk);
        issue_valid = 1'b0;
        chk("t6_valid", 64'(out_valid), 64'd1);
        drain("t6");

        chk("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
